ifid_fetch_stage: RTL and testbench

- Fetch stage of the 5-stage MIPS pipeline: PC register, next-PC select and IF/ID pipeline register.
- Consumes stall/flush from the hazard unit and PCSrcID from decode.
- Holds PC and IF/ID on stall; squashes IF/ID to a NOP bubble on redirect.
- Accepts external interrupts only at safe points, outside kernel mode; records the return address in EPC.

---
 rtl/ifid_fetch_stage.sv | 112 +++++++++++
 tb/tb_ifid_fetch_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ifid_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select, interrupt entry and IF/ID pipeline register.
// Optional `IFID_PERF_CNT_EN adds saturating stall/flush event counters.
module ifid_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h80000000,
    parameter logic [31:0] ILLOP_PC  = 32'h80000004,
    parameter logic [31:0] XADR_PC   = 32'h80000008,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        interrupt,
    input  logic [2:0]  PCSrcID,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_if,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id,
    output logic [31:0] epc,
    output logic        epc_we
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    logic        pendingQ;
    logic        intPrevQ;
    logic        accept;
    logic        bubble;
    logic [31:0] pcPlus4;
    logic [31:0] pcNext;

    assign pcPlus4 = pc_if + 32'd4;

    // Interrupts only enter from user mode, and never while the pipe is redirecting or held.
    always_comb begin
        accept = pendingQ & ~pc_if[31] & ~stall & (PCSrcID == 3'd0);
        bubble = flush | accept;
        pcNext = pcPlus4;
        if (accept) begin
            pcNext = ILLOP_PC;
        end else begin
            case (PCSrcID)
                3'd0:    pcNext = pcPlus4;
                3'd1:    pcNext = branch_target;
                3'd2:    pcNext = jump_target;
                3'd3:    pcNext = jr_target;
                3'd4:    pcNext = ILLOP_PC;
                default: pcNext = XADR_PC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_if       <= RESET_PC;
            instr_id    <= NOP_INSTR;
            pc_plus4_id <= 32'd0;
            valid_id    <= 1'b0;
            epc         <= 32'd0;
            epc_we      <= 1'b0;
            pendingQ    <= 1'b0;
            intPrevQ    <= 1'b0;
        end else begin
            intPrevQ <= interrupt;
            // A still-high request after acceptance must not re-arm; only a new rising level does.
            if (accept) begin
                pendingQ <= 1'b0;
            end else if (interrupt && !intPrevQ) begin
                pendingQ <= 1'b1;
            end
            epc_we <= accept;
            if (!stall) begin
                pc_if       <= pcNext;
                pc_plus4_id <= pcPlus4;
                if (bubble) begin
                    instr_id <= NOP_INSTR;
                    valid_id <= 1'b0;
                end else begin
                    instr_id <= imem_instr;
                    valid_id <= 1'b1;
                end
                if (accept) begin
                    epc <= pc_if;
                end
            end
        end
    end

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall && stall_cnt != 32'hFFFFFFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!stall && bubble && flush_cnt != 32'hFFFFFFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Self-checking bench for ifid_fetch_stage: directed scenarios plus a randomized run
// compared against a rule-level reference model.
module tb_ifid_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam logic [31:0] ILLOP_PC = 32'h80000004;
    localparam logic [31:0] XADR_PC  = 32'h80000008;

    logic        clk = 1'b0;
    logic        reset, stall, flush, interrupt;
    logic [2:0]  PCSrcID;
    logic [31:0] branch_target, jump_target, jr_target, imem_instr;
    logic [31:0] pc_if, instr_id, pc_plus4_id, epc;
    logic        valid_id, epc_we;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mPc, mInstr, mPc4, mEpc, mStallCnt, mFlushCnt;
    logic        mValid, mEpcWe, mPending, mIntLast;

    always #5 clk = ~clk;

    ifid_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .interrupt     (interrupt),
        .PCSrcID       (PCSrcID),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .imem_instr    (imem_instr),
        .pc_if         (pc_if),
        .instr_id      (instr_id),
        .pc_plus4_id   (pc_plus4_id),
        .valid_id      (valid_id),
        .epc           (epc),
        .epc_we        (epc_we)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    // Redirect without flush is a hazard-unit inconsistency.
    always @(posedge clk) begin
        if (!reset && !stall && PCSrcID != 3'd0 && !flush)
            $warning("hazard inconsistency: PCSrcID=%0d without flush", PCSrcID);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".pc_if"}, pc_if, mPc);
        check({tag, ".instr_id"}, instr_id, mInstr);
        check({tag, ".pc_plus4_id"}, pc_plus4_id, mPc4);
        check({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, mValid});
        check({tag, ".epc"}, epc, mEpc);
        check({tag, ".epc_we"}, {31'd0, epc_we}, {31'd0, mEpcWe});
`ifdef IFID_PERF_CNT_EN
        check({tag, ".stall_cnt"}, stall_cnt, mStallCnt);
        check({tag, ".flush_cnt"}, flush_cnt, mFlushCnt);
`endif
    endtask

    task automatic doReset(input logic [31:0] ins);
        reset = 1'b1; stall = 1'b0; flush = 1'b0; interrupt = 1'b0; PCSrcID = 3'd0;
        branch_target = 32'd0; jump_target = 32'd0; jr_target = 32'd0; imem_instr = ins;
        @(posedge clk); #1;
        mPc = RESET_PC; mInstr = 32'd0; mPc4 = 32'd0; mValid = 1'b0; mEpc = 32'd0;
        mEpcWe = 1'b0; mPending = 1'b0; mIntLast = 1'b0; mStallCnt = 32'd0; mFlushCnt = 32'd0;
        checkAll("reset");
        reset = 1'b0;
    endtask

    // One clock: drive inputs, predict from the rules, compare after the edge.
    task automatic step(input string tag, input logic st, input logic fl, input logic intr,
                        input logic [2:0] src, input logic [31:0] tgt, input logic [31:0] ins);
        logic        acc;
        logic [31:0] nPc;
        stall = st; flush = fl; interrupt = intr; PCSrcID = src; imem_instr = ins;
        branch_target = $urandom; jump_target = $urandom; jr_target = $urandom;
        if (src == 3'd1) branch_target = tgt;
        if (src == 3'd2) jump_target = tgt;
        if (src == 3'd3) jr_target = tgt;
        acc = mPending && !mPc[31] && !st && src == 3'd0;
        case (src)
            3'd0: nPc = mPc + 32'd4;
            3'd1: nPc = branch_target;
            3'd2: nPc = jump_target;
            3'd3: nPc = jr_target;
            3'd4: nPc = ILLOP_PC;
            default: nPc = XADR_PC;
        endcase
        if (acc) nPc = ILLOP_PC;
        @(posedge clk); #1;
        if (st && mStallCnt != 32'hFFFFFFFF) mStallCnt = mStallCnt + 1;
        if (!st && (fl || acc) && mFlushCnt != 32'hFFFFFFFF) mFlushCnt = mFlushCnt + 1;
        if (!st) begin
            mPc4   = mPc + 32'd4;
            mInstr = (fl || acc) ? 32'd0 : ins;
            mValid = !(fl || acc);
            if (acc) mEpc = mPc;
            mPc    = nPc;
        end
        mEpcWe = acc;
        if (acc) mPending = 1'b0;
        else if (intr && !mIntLast) mPending = 1'b1;
        mIntLast = intr;
        checkAll(tag);
    endtask

    initial begin
        logic [2:0]  rs;
        logic [31:0] rt;
        logic        rf;

        // Reset and sequential fetch
        doReset(32'h20080001);
        check("tp.reset_pc", pc_if, 32'h80000000);
        step("seq1", 0, 0, 0, 3'd0, 32'd0, 32'h20080001);
        check("tp.seq1_pc", pc_if, 32'h80000004);
        check("tp.seq1_instr", instr_id, 32'h20080001);
        check("tp.seq1_valid", {31'd0, valid_id}, 32'd1);
        check("tp.seq1_pc4", pc_plus4_id, 32'h80000004);
        step("seq2", 0, 0, 0, 3'd0, 32'd0, 32'h20080001);
        check("tp.seq2_pc", pc_if, 32'h80000008);

        // Stall for two cycles at 00400010
        step("j10", 0, 1, 0, 3'd2, 32'h00400010, 32'h11111111);
        step("fill", 0, 0, 0, 3'd0, 32'd0, 32'h22222222);
        step("j10b", 0, 1, 0, 3'd2, 32'h00400010, 32'h33333333);
        check("tp.at10", pc_if, 32'h00400010);
        step("stall1", 1, 0, 0, 3'd0, 32'd0, 32'h44444444);
        check("tp.stall1_pc", pc_if, 32'h00400010);
        check("tp.stall1_instr", instr_id, 32'h0);
        step("stall2", 1, 0, 0, 3'd0, 32'd0, 32'h55555555);
        check("tp.stall2_pc", pc_if, 32'h00400010);
        step("unstall", 0, 0, 0, 3'd0, 32'd0, 32'h66666666);
        check("tp.unstall_pc", pc_if, 32'h00400014);

        // Branch with flush
        step("br", 0, 1, 0, 3'd1, 32'h00400100, 32'h77777777);
        check("tp.br_pc", pc_if, 32'h00400100);
        check("tp.br_instr", instr_id, 32'h0);
        check("tp.br_valid", {31'd0, valid_id}, 32'd0);

        // User-mode interrupt: request arrives while jumping to 00400020
        step("j20", 0, 1, 1, 3'd2, 32'h00400020, 32'h0);
        step("acc1", 0, 0, 0, 3'd0, 32'd0, 32'h12345678);
        check("tp.acc1_pc", pc_if, 32'h80000004);
        check("tp.acc1_epc", epc, 32'h00400020);
        check("tp.acc1_we", {31'd0, epc_we}, 32'd1);
        check("tp.acc1_valid", {31'd0, valid_id}, 32'd0);
        step("acc1b", 0, 0, 0, 3'd0, 32'd0, 32'h12345678);
        check("tp.acc1b_we", {31'd0, epc_we}, 32'd0);

        // Kernel mode: request pends until jr returns to user mode
        step("j80", 0, 1, 1, 3'd2, 32'h80000020, 32'h0);
        step("k1", 0, 0, 0, 3'd0, 32'd0, 32'hAAAA0001);
        check("tp.k1_pc", pc_if, 32'h80000024);
        check("tp.k1_we", {31'd0, epc_we}, 32'd0);
        step("k2", 0, 0, 0, 3'd0, 32'd0, 32'hAAAA0002);
        step("jr", 0, 1, 0, 3'd3, 32'h00400024, 32'h0);
        check("tp.jr_pc", pc_if, 32'h00400024);
        step("acc2", 0, 0, 0, 3'd0, 32'd0, 32'hBBBB0000);
        check("tp.acc2_pc", pc_if, 32'h80000004);
        check("tp.acc2_epc", epc, 32'h00400024);
        check("tp.acc2_we", {31'd0, epc_we}, 32'd1);

        // Stall overrides flush
        step("sf", 1, 1, 0, 3'd2, 32'h00500000, 32'hCCCC0000);
        check("tp.sf_pc", pc_if, 32'h80000004);
        check("tp.sf_epc", epc, 32'h00400024);

        // 32-bit PC wrap
        step("jwrap", 0, 1, 0, 3'd2, 32'hFFFFFFFC, 32'h0);
        step("wrap", 0, 0, 0, 3'd0, 32'd0, 32'hDDDD0000);
        check("tp.wrap_pc", pc_if, 32'h00000000);
        check("tp.wrap_pc4", pc_plus4_id, 32'h00000000);

`ifdef IFID_PERF_CNT_EN
        doReset(32'h0);
        for (int i = 0; i < 3; i++) step("pstall", 1, 0, 0, 3'd0, 32'd0, 32'h1);
        for (int i = 0; i < 2; i++) step("pflush", 0, 1, 0, 3'd1, 32'h00400000, 32'h2);
        check("tp.stall_cnt", stall_cnt, 32'd3);
        check("tp.flush_cnt", flush_cnt, 32'd2);
`endif

        // Randomized run against the model
        doReset($urandom);
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 7));
            rf = (rs != 3'd0) ? 1'b1 : ($urandom_range(0, 9) == 0);
            rt = {$urandom_range(0, 1) == 1, 29'($urandom), 2'b00};
            step("rand", $urandom_range(0, 3) == 0, rf, $urandom_range(0, 5) == 0, rs, rt,
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
